// File: rtl/lcd_touch_int_pkg.sv
// Shared definitions for the multi-channel touch/gesture/button interrupt port.
// Holds the Avalon register word addresses and the per-channel capture-mode
// encoding used by the MODE register (2 bits per channel).
package lcd_touch_int_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd4;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_t;

endpackage

// File: rtl/lcd_int_debounce.sv
// One interrupt channel front end: two-flop synchroniser followed by a
// debounce filter. The filtered level only changes after the synchronised
// input has disagreed with it for thresh_i consecutive cycles.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset
//   in_i      asynchronous external line
//   thresh_i  debounce threshold in cycles (0 = no filtering)
//   stable_o  debounced level
module lcd_int_debounce
  import lcd_touch_int_pkg::*;
#(
  parameter int unsigned DEB_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_i,
  input  logic [DEB_W-1:0] thresh_i,
  output logic             stable_o
);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering the threshold below an in-flight
  // count still lets the channel update; the counter never exceeds
  // thresh_i-1, so it cannot wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (thresh_i == '0) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh_i - 1'b1) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= in_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/lcd_touch_int_multi.sv
// Avalon-MM interrupt input port for WIDTH external lines (touch, gesture,
// buttons). Each line is synchronised and debounced, then captured per its
// MODE field into write-1-to-clear EDGECAP bits; irq is the OR of the
// captured bits enabled by IRQMASK.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   address, chipselect Avalon word address / select
//   write_n, writedata  Avalon active-low write strobe and data
//   in_port             asynchronous interrupt lines
//   readdata            registered read data (1 cycle latency)
//   irq                 active-high interrupt request
module lcd_touch_int_multi
  import lcd_touch_int_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEB_W      = 16,
  parameter logic [31:0] RESET_MODE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned MW = 2 * WIDTH;

  logic             wr;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_q;
  logic [WIDTH-1:0] rise, fall, set, clr;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [MW-1:0]    mode_q, mode_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wdata;

  // Upper writedata bits are unused for narrow configurations.
  assign unused_wdata = ^writedata;

  assign wr = chipselect & ~write_n;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    lcd_int_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk_i    (clk),
      .reset_i  (reset),
      .in_i     (in_port[g]),
      .thresh_i (deb_q),
      .stable_o (stable[g])
    );
  end

  always_comb begin
    rise = stable & ~stable_d_q;
    fall = ~stable & stable_d_q;
    set  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (mode_t'(mode_q[2*i +: 2]))
        MODE_RISE:  set[i] = rise[i];
        MODE_FALL:  set[i] = fall[i];
        MODE_BOTH:  set[i] = rise[i] | fall[i];
        MODE_LEVEL: set[i] = stable[i];
        default:    set[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    clr        = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    // A new event wins over a simultaneous clear.
    edge_cap_d = set | (edge_cap_q & ~clr);
    mode_d     = mode_q;
    irq_mask_d = irq_mask_q;
    deb_d      = deb_q;
    if (wr) begin
      case (address)
        ADDR_MODE:     mode_d     = writedata[MW-1:0];
        ADDR_IRQMASK:  irq_mask_d = writedata[WIDTH-1:0];
        ADDR_DEBOUNCE: deb_d      = writedata[DEB_W-1:0];
        default:       ;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = stable;
      ADDR_MODE:     readdata_d[MW-1:0]    = mode_q;
      ADDR_IRQMASK:  readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP:  readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_DEBOUNCE: readdata_d[DEB_W-1:0] = deb_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d_q <= '0;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      mode_q     <= RESET_MODE[MW-1:0];
      deb_q      <= '0;
      readdata_q <= '0;
    end else begin
      stable_d_q <= stable;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      mode_q     <= mode_d;
      deb_q      <= deb_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
